scan_linebuf_ctrl: RTL and testbench

- Controller for the scan converter's ping-pong line buffer.
- Shares one single-port line RAM, holding two banks of 2^AW pixels, between two requesters:
  - the capture writer, driven by the CGA/EGA timing-generator counts;
  - the doubled-rate output reader.
- Sequences bank swaps per input line.
- Counts active input lines per frame using mode-dependent line totals.
- Flags write overflow.

---
 rtl/scan_linebuf_ctrl.sv | 157 +++++++++++++++
 tb/tb_scan_linebuf_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_linebuf_ctrl.sv
// Ping-pong line buffer controller for the scan converter.
// One single-port RAM holds two banks of 2^AW pixels. The capture side writes
// one bank while the doubled-rate output side reads the other. Reads always
// win the RAM port. A colliding write is parked in a one-entry hold register
// and drains on the next free cycle.
module scan_linebuf_ctrl #(
  parameter int AW        = 9,
  parameter int DW        = 4,
  parameter int CGA_LINES = 200,
  parameter int EGA_LINES = 350
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          egamode,
  input  logic          in_fs,
  input  logic          in_ls,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          out_ls,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic [8:0]    line_cnt,
  output logic          active,
  output logic          overflow
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  localparam logic [8:0] CGA_TGT = 9'(CGA_LINES);
  localparam logic [8:0] EGA_TGT = 9'(EGA_LINES);

  state_t        state;
  logic [8:0]    lines_tgt;
  logic          hold_valid;
  logic [AW:0]   hold_addr;
  logic [DW-1:0] hold_data;

  logic wr_accept;
  logic ls_active;
  logic hold_drain;
  logic hold_load;
  logic wr_drop;

  // Captures are only taken while a frame is in progress.
  assign wr_accept  = wr_req && (state == ACTIVE);
  assign ls_active  = in_ls && (state == ACTIVE);
  // The hold register drains whenever the reader leaves the port free.
  assign hold_drain = hold_valid && !rd_req;
  // The hold register is loaded when a write collides with a read on an empty
  // hold, or when it is draining and a new write arrives behind it.
  assign hold_load  = wr_accept && (rd_req ? !hold_valid : hold_valid);
  assign wr_drop    = wr_accept && rd_req && hold_valid;

  assign active  = (state == ACTIVE);
  assign rd_data = ram_rdata;

  // Frame state machine: line counting, frame arming and bank sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      line_cnt  <= '0;
      lines_tgt <= CGA_TGT;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every branch reads the
      // pre-edge values of state, line_cnt and wr_bank, regardless of order.
      if (ls_active) wr_bank <= ~wr_bank;
      // The reader normally takes the bank not being written; if a line ends
      // on the same edge, it takes the line that just completed.
      if (out_ls) rd_bank <= ls_active ? wr_bank : ~wr_bank;

      if (!enable) begin
        state    <= IDLE;
        line_cnt <= '0;
      end else begin
        case (state)
          IDLE: state <= WAIT_FRAME;
          WAIT_FRAME: begin
            if (in_fs) begin
              state     <= ACTIVE;
              line_cnt  <= '0;
              lines_tgt <= egamode ? EGA_TGT : CGA_TGT;
            end
          end
          ACTIVE: begin
            if (in_fs) begin
              // Resync: restart the count, keep capturing.
              line_cnt  <= '0;
              lines_tgt <= egamode ? EGA_TGT : CGA_TGT;
            end else if (in_ls) begin
              if (line_cnt == lines_tgt - 9'd1) begin
                line_cnt <= '0;
                state    <= WAIT_FRAME;
              end else begin
                line_cnt <= line_cnt + 9'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // RAM port arbitration: read, then held write, then direct write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_re     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      rd_valid   <= 1'b0;
      hold_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ram_re   <= rd_req;
      ram_we   <= !rd_req && (hold_valid || wr_accept);
      rd_valid <= ram_re;

      if (rd_req)          ram_addr <= {rd_bank, rd_addr};
      else if (hold_valid) ram_addr <= hold_addr;
      else if (wr_accept)  ram_addr <= {wr_bank, wr_addr};

      if (hold_load)       hold_valid <= 1'b1;
      else if (hold_drain) hold_valid <= 1'b0;

      if (wr_drop) overflow <= 1'b1;
    end
  end

  // Write data path: payload registers qualified by hold_valid / ram_we.
  // NOTE: no reset on these; their contents are never used unless a valid
  // flag or write strobe that is itself reset says so.
  always_ff @(posedge clk) begin
    if (hold_load) begin
      hold_addr <= {wr_bank, wr_addr};
      hold_data <= wr_data;
    end
    if (!rd_req) ram_wdata <= hold_valid ? hold_data : wr_data;
  end

endmodule

// File: tb/tb_scan_linebuf_ctrl.sv
// Self-checking bench for scan_linebuf_ctrl: a directed vector table for the
// arbitration cases plus hand-written sequences for line counting, read-bank
// selection, EGA resync and reset.
module tb_scan_linebuf_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, egamode, in_fs, in_ls, wr_req, out_ls, rd_req;
  logic [8:0] wr_addr, rd_addr;
  logic [3:0] wr_data, rd_data, ram_wdata, ram_rdata;
  logic       rd_valid, ram_we, ram_re, wr_bank, rd_bank, active, overflow;
  logic [9:0] ram_addr;
  logic [8:0] line_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_linebuf_ctrl #(.AW(9), .DW(4), .CGA_LINES(200), .EGA_LINES(350)) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .egamode(egamode),
    .in_fs(in_fs), .in_ls(in_ls), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .out_ls(out_ls), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata), .wr_bank(wr_bank), .rd_bank(rd_bank),
    .line_cnt(line_cnt), .active(active), .overflow(overflow)
  );

  // Behavioural single-port RAM with one-cycle read latency.
  logic [3:0] mem [0:1023];
  logic [3:0] rdata_q;
  assign ram_rdata = rdata_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 4'd0;
      rdata_q <= 4'd0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_re) rdata_q <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    enable = 1'b1; egamode = 1'b0; in_fs = 1'b0; in_ls = 1'b0; out_ls = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
  endtask

  // One-cycle strobe pulse on the timing inputs.
  task automatic pulse(input logic fs, input logic ls, input logic ols, input logic eg);
    in_fs = fs; in_ls = ls; out_ls = ols; egamode = eg;
    step();
    in_fs = 1'b0; in_ls = 1'b0; out_ls = 1'b0;
  endtask

  typedef struct {
    int en, fs, ls, ols, rd, ra, wr, wa, wd;
    int x_re, x_we, x_addr, x_wd, x_rv, chk_rd, x_rd, x_wb, x_rb, x_lc, x_act, x_ov;
  } vec_t;

  vec_t vq[$];

  initial begin
    // en fs ls ols rd ra wr wa wd | re we addr wdat rv chk rdat wb rb lc act ov
    vq.push_back('{1,1,0,0, 0,0, 0, 0,0,   0,0,'h000,0, 0,0,0,   0,1,0,1,0}); // arm CGA
    vq.push_back('{1,0,0,0, 1,5, 1, 7,'hA, 1,0,'h205,0, 0,0,0,   0,1,0,1,0}); // read wins
    vq.push_back('{1,0,0,0, 0,0, 0, 0,0,   0,1,'h007,'hA,1,0,0,  0,1,0,1,0}); // held write lands
    vq.push_back('{1,0,1,0, 0,0, 0, 0,0,   0,0,'h000,0, 0,0,0,   1,1,1,1,0}); // line end
    vq.push_back('{1,0,0,1, 0,0, 0, 0,0,   0,0,'h000,0, 0,0,0,   1,0,1,1,0}); // out_ls -> bank 0
    vq.push_back('{1,0,0,0, 1,7, 0, 0,0,   1,0,'h007,0, 0,0,0,   1,0,1,1,0}); // read back pixel 7
    vq.push_back('{1,0,0,0, 0,0, 0, 0,0,   0,0,'h000,0, 1,1,'hA, 1,0,1,1,0}); // data returns
    vq.push_back('{1,0,0,0, 1,0, 1,20,5,   1,0,'h000,0, 0,0,0,   1,0,1,1,0}); // hold 0x214
    vq.push_back('{1,0,0,0, 0,0, 1,21,6,   0,1,'h214,5, 1,0,0,   1,0,1,1,0}); // drain + refill
    vq.push_back('{1,0,0,0, 0,0, 0, 0,0,   0,1,'h215,6, 0,0,0,   1,0,1,1,0}); // refill drains
    vq.push_back('{1,0,0,0, 0,0, 1,30,7,   0,1,'h21E,7, 0,0,0,   1,0,1,1,0}); // direct write
    vq.push_back('{1,0,0,0, 1,4, 1,40,9,   1,0,'h004,0, 0,0,0,   1,0,1,1,0}); // hold 0x228
    vq.push_back('{0,0,0,0, 0,0, 0, 0,0,   0,1,'h228,9, 1,0,0,   1,0,0,0,0}); // enable drop flushes
    vq.push_back('{0,0,0,0, 1,6, 1,41,8,   1,0,'h006,0, 0,0,0,   1,0,0,0,0}); // idle: write ignored
    vq.push_back('{0,0,0,0, 0,0, 1,42,8,   0,0,'h000,0, 1,0,0,   1,0,0,0,0}); // no write issued
    vq.push_back('{0,0,0,0, 1,1, 1,43,8,   1,0,'h001,0, 0,0,0,   1,0,0,0,0}); // still no overflow
    vq.push_back('{1,0,0,0, 0,0, 0, 0,0,   0,0,'h000,0, 1,0,0,   1,0,0,0,0}); // re-arm
    vq.push_back('{1,1,0,0, 0,0, 0, 0,0,   0,0,'h000,0, 0,0,0,   1,0,0,1,0}); // frame start
    vq.push_back('{1,0,0,0, 1,1, 1,10,1,   1,0,'h001,0, 0,0,0,   1,0,0,1,0}); // first write held
    vq.push_back('{1,0,0,0, 1,2, 1,11,2,   1,0,'h002,0, 1,0,0,   1,0,0,1,1}); // second dropped
    vq.push_back('{1,0,0,0, 1,3, 1,12,3,   1,0,'h003,0, 1,0,0,   1,0,0,1,1}); // third dropped
    vq.push_back('{1,0,0,0, 0,0, 0, 0,0,   0,1,'h20A,1, 1,0,0,   1,0,0,1,1}); // held write lands
    vq.push_back('{1,0,0,0, 0,0, 0, 0,0,   0,0,'h000,0, 0,0,0,   1,0,0,1,1}); // sticky overflow

    clear_inputs();
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset wr_bank", int'(wr_bank), 0);
    check("reset rd_bank", int'(rd_bank), 1);
    check("reset line_cnt", int'(line_cnt), 0);
    check("reset active", int'(active), 0);
    check("reset overflow", int'(overflow), 0);
    check("reset ram_re/we", int'({ram_re, ram_we}), 0);
    check("reset ram_addr", int'(ram_addr), 0);
    check("reset rd_valid", int'(rd_valid), 0);
    rst_n = 1'b1;
    step();

    // Arm and run one CGA frame of 200 lines.
    enable = 1'b1;
    step();
    check("arm waits for fs", int'(active), 0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("active after fs", int'(active), 1);
    check("line_cnt after fs", int'(line_cnt), 0);
    for (int i = 0; i < 200; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("cga line_cnt %0d", i), int'(line_cnt), (i + 1) % 200);
      check($sformatf("cga wr_bank %0d", i), int'(wr_bank), (i + 1) % 2);
      check($sformatf("cga active %0d", i), int'(active), (i == 199) ? 0 : 1);
    end

    // Table-driven arbitration vectors.
    for (int n = 0; n < vq.size(); n++) begin
      enable  = vq[n].en[0];   in_fs   = vq[n].fs[0];  in_ls  = vq[n].ls[0];
      out_ls  = vq[n].ols[0];  rd_req  = vq[n].rd[0];  rd_addr = 9'(vq[n].ra);
      wr_req  = vq[n].wr[0];   wr_addr = 9'(vq[n].wa); wr_data = 4'(vq[n].wd);
      egamode = 1'b0;
      step();
      check($sformatf("v%0d ram_re", n), int'(ram_re), vq[n].x_re);
      check($sformatf("v%0d ram_we", n), int'(ram_we), vq[n].x_we);
      if (vq[n].x_re != 0 || vq[n].x_we != 0)
        check($sformatf("v%0d ram_addr", n), int'(ram_addr), vq[n].x_addr);
      if (vq[n].x_we != 0)
        check($sformatf("v%0d ram_wdata", n), int'(ram_wdata), vq[n].x_wd);
      check($sformatf("v%0d rd_valid", n), int'(rd_valid), vq[n].x_rv);
      if (vq[n].chk_rd != 0)
        check($sformatf("v%0d rd_data", n), int'(rd_data), vq[n].x_rd);
      check($sformatf("v%0d wr_bank", n), int'(wr_bank), vq[n].x_wb);
      check($sformatf("v%0d rd_bank", n), int'(rd_bank), vq[n].x_rb);
      check($sformatf("v%0d line_cnt", n), int'(line_cnt), vq[n].x_lc);
      check($sformatf("v%0d active", n), int'(active), vq[n].x_act);
      check($sformatf("v%0d overflow", n), int'(overflow), vq[n].x_ov);
    end
    clear_inputs();

    // Read-bank selection; starts ACTIVE with wr_bank=1, rd_bank=0.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    check("rb pre wr_bank", int'(wr_bank), 0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("rb out_ls wb0", int'(rd_bank), 1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("rb out_ls wb1", int'(rd_bank), 0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("rb out_ls wb0 again", int'(rd_bank), 1);
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    check("rb coincident rd_bank", int'(rd_bank), 0);
    check("rb coincident wr_bank", int'(wr_bank), 1);
    check("rb coincident line_cnt", int'(line_cnt), 4);

    // in_fs and in_ls together: count restarts, bank still toggles.
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("fs+ls line_cnt", int'(line_cnt), 0);
    check("fs+ls wr_bank", int'(wr_bank), 0);
    check("fs+ls active", int'(active), 1);

    // EGA resync: switch to 350 lines, 120 lines, resync, full frame.
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("ega fs line_cnt", int'(line_cnt), 0);
    for (int i = 0; i < 120; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("ega pre line_cnt %0d", i), int'(line_cnt), i + 1);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    check("resync line_cnt", int'(line_cnt), 0);
    check("resync active", int'(active), 1);
    check("resync wr_bank", int'(wr_bank), 0);
    for (int i = 0; i < 350; i++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("ega line_cnt %0d", i), int'(line_cnt), (i + 1) % 350);
      check($sformatf("ega active %0d", i), int'(active), (i == 349) ? 0 : 1);
    end
    check("ega end wr_bank", int'(wr_bank), 0);

    // Reset while a write is held: the held write must not appear afterwards.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    rd_req = 1'b1; wr_req = 1'b1; wr_addr = 9'd3; wr_data = 4'd5;
    step();
    rd_req = 1'b0; wr_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async reset ram_re", int'(ram_re), 0);
    check("async reset overflow", int'(overflow), 0);
    check("async reset rd_bank", int'(rd_bank), 1);
    step();
    rst_n = 1'b1;
    step();
    check("held write discarded", int'(ram_we), 0);
    check("post reset active", int'(active), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
